wb_initiator: RTL and testbench
===============================

// Module: wb_initiator
// PURPOSE
//  Wishbone classic initiator: turns single requests from a core-side valid/ready port into one
//  Wishbone cycle (cyc/stb/we/sel/adr/dat), waits for ack_i/err_i or a timeout, and returns the
//  result on a valid/ready response port. Sits between the CPU load/store path and the
//  peripheral bus (GPIO and other responders). One outstanding transaction, no pipelining.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; SEL_W = DATA_W/8
//  TIMEOUT  255  max cycles stb_o stays high without ack_i/err_i before forced error (>=1)
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        reset, asynchronous, active-high
//  req_valid  in   1        core request valid
//  req_ready  out  1        initiator can accept request (high only in IDLE)
//  req_we     in   1        1 = write, 0 = read
//  req_addr   in   ADDR_W   byte address
//  req_wdata  in   DATA_W   write data
//  req_sel    in   SEL_W    byte lanes
//  rsp_valid  out  1        response valid, held until rsp_ready
//  rsp_ready  in   1        core accepts response
//  rsp_rdata  out  DATA_W   read data (0 for writes and errors)
//  rsp_err    out  1        1 = err_i received or timeout
//  adr_o      out  ADDR_W   Wishbone address
//  dat_o      out  DATA_W   Wishbone write data
//  dat_i      in   DATA_W   Wishbone read data
//  we_o       out  1        Wishbone write enable
//  sel_o      out  SEL_W    Wishbone byte select
//  cyc_o      out  1        Wishbone cycle
//  stb_o      out  1        Wishbone strobe
//  ack_i      in   1        Wishbone acknowledge
//  err_i      in   1        Wishbone error
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; cyc_o, stb_o, we_o, rsp_valid, rsp_err = 0;
//    adr_o, dat_o, sel_o, rsp_rdata, timeout counter = 0. Reset mid-cycle drops cyc/stb at once;
//    the in-flight transaction is lost, no response is produced.
//  - States: IDLE, BUS, RESP. All bus and response outputs are registered.
//  - IDLE: req_ready = 1. On req_valid: latch addr/wdata/sel/we into adr_o/dat_o/sel_o/we_o,
//    set cyc_o = stb_o = 1, clear counter, go BUS. A request arriving at edge N shows stb_o in N+1.
//  - BUS: req_ready = 0; counter increments each cycle. At the edge sampling:
//      err_i=1            -> rsp_err=1, rsp_rdata=0 (err has priority over ack)
//      ack_i=1, err_i=0   -> rsp_err=0; rsp_rdata = we_o ? 0 : dat_i
//      neither, counter==TIMEOUT-1 -> rsp_err=1, rsp_rdata=0 (ack on the same edge wins)
//    In each case cyc_o = stb_o = 0, rsp_valid = 1, go RESP, so stb never overlaps a
//    registered-ack responder's second ack cycle.
//  - RESP: rsp_valid = 1, outputs stable; on rsp_ready -> rsp_valid = 0, go IDLE. New request
//    accepted earliest the cycle after return to IDLE (no bypass).
//  - Latency with 1-cycle registered-ack responder: req edge N, ack seen N+2, rsp_valid N+3.
//  - ack_i/err_i outside BUS are ignored. we_o/adr_o/dat_o/sel_o hold last values in IDLE/RESP.
//  - Counter width clog2(TIMEOUT+1); saturates, never wraps.
// STRUCTURE
//  - Shared include wb_defs.vh: state encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2), default
//    ADDR_W/DATA_W, default bus timeout.
//  - One sub-module: wb_timeout_ctr (clear, enable, expired flag at TIMEOUT-1), reusable by
//    other bus masters. FSM and data registers stay in wb_initiator.
// TESTING (bench with wb_gpio-style responder: registered ack one cycle after cyc&stb&~ack)
//  1 write: req addr=0x2, wdata=0x1, sel=0xF, we=1 -> stb_o 1 cycle after accept, ack 1 later,
//    rsp_valid=1, rsp_err=0, rsp_rdata=0; responder bit 2 = 1; stb_o high exactly 2 cycles.
//  2 read: gpio_i=4'b0100, req addr=0x2 we=0 -> rsp_rdata=0x00000001, rsp_err=0, rsp_valid N+3.
//  3 timeout: TIMEOUT=4, no responder ack -> stb_o high 4 cycles, then rsp_err=1, rsp_rdata=0.
//  4 err/ack priority: err_i and ack_i together -> rsp_err=1; ack at timeout edge -> rsp_err=0.
//  5 backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0, new
//    req_valid ignored; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
//  6 reset mid-BUS: assert rst while stb_o=1 -> cyc_o/stb_o=0 without clock edge, no rsp_valid.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone classic initiator: default widths, bus timeout,
// FSM state encoding and the rule that resolves a bus cycle's outcome.
package wb_initiator_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic done;       // the bus cycle ends on this edge
    logic err;        // response reports an error
    logic take_data;  // a clean ack: read data may be captured
  } bus_outcome_t;

  // err_i beats ack_i; ack_i beats a timeout landing on the same edge.
  function automatic bus_outcome_t resolve_outcome(input logic ack,
                                                   input logic err,
                                                   input logic expired);
    bus_outcome_t o;
    o.done      = ack | err | expired;
    o.err       = err | (expired & ~ack);
    o.take_data = ack & ~err;
    return o;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle watchdog: cleared when a cycle starts, counts while enabled and
// flags expiry once the count reaches TIMEOUT-1. Usable by any bus master.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == EXPIRE_AT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one core request becomes one registered cyc/stb cycle,
// terminated by ack_i, err_i or a timeout, and reported on a held valid/ready response.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // core request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SEL_W-1:0]  req_sel,
  // core response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // Wishbone bus
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  output logic              we_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i,
  input  logic              err_i
);

  wb_state_e state_q, state_d;

  logic [ADDR_W-1:0] adr_q,       adr_d;
  logic [DATA_W-1:0] dat_q,       dat_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic              we_q,        we_d;
  logic              bus_q,       bus_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic         accept;
  logic         ctr_clear;
  logic         ctr_en;
  logic         expired;
  bus_outcome_t outcome;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (ctr_clear),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign outcome = resolve_outcome(ack_i, err_i, expired);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      bus_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)    state_d = ST_BUS;
      ST_BUS:  if (outcome.done) state_d = ST_RESP;
      ST_RESP: if (rsp_ready)    state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Bus/response register updates; ack_i and err_i only matter while in BUS.
  always_comb begin
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    bus_d       = bus_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          adr_d     = req_addr;
          dat_d     = req_wdata;
          sel_d     = req_sel;
          we_d      = req_we;
          bus_d     = 1'b1;
          ctr_clear = 1'b1;
        end
      end
      ST_BUS: begin
        ctr_en = 1'b1;
        if (outcome.done) begin
          bus_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = outcome.err;
          rsp_rdata_d = (outcome.take_data && !we_q) ? dat_i : '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;
  assign we_o      = we_q;
  assign cyc_o     = bus_q;
  assign stb_o     = bus_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a GPIO-style registered-ack responder plus a programmable
// delayed ack/err responder, checked against a cycle-count reference model.
module tb_wb_initiator;

  localparam int unsigned TMO = 4;
  localparam int M_GPIO  = 0;
  localparam int M_NONE  = 1;
  localparam int M_DELAY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        we_o, cyc_o, stb_o, ack_i, err_i;
  logic [3:0]  sel_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // responder configuration, set by the tests
  int          mode = M_GPIO;
  int          dly_w = 0;
  logic        dly_ack = 1'b0, dly_err = 1'b0;
  logic [31:0] rand_dat = '0;
  logic [3:0]  gpio_i = '0;
  logic [3:0]  gpio_out;
  logic        gpio_ack;
  int          stb_seen;

  wb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk = ~clk;

  // GPIO-style responder: registered ack one cycle after cyc&stb&~ack, bit-addressed pins
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_ack <= 1'b0;
      gpio_out <= '0;
    end else begin
      gpio_ack <= (mode == M_GPIO) && cyc_o && stb_o && !gpio_ack;
      if ((mode == M_GPIO) && cyc_o && stb_o && !gpio_ack && we_o)
        gpio_out[adr_o[1:0]] <= dat_o[0];
    end
  end

  // Delayed responder: drives ack/err while stb has been seen on exactly dly_w prior edges
  always @(posedge clk) begin
    if (stb_o) stb_seen <= stb_seen + 1;
    else       stb_seen <= 0;
  end

  assign ack_i = (mode == M_GPIO) ? gpio_ack
               : ((mode == M_DELAY) && stb_o && (stb_seen == dly_w) && dly_ack);
  assign err_i = (mode == M_DELAY) && stb_o && (stb_seen == dly_w) && dly_err;
  assign dat_i = (mode == M_GPIO) ? {31'b0, gpio_i[adr_o[1:0]]} : rand_dat;

  // Issues one request and observes the bus: stb_cycles = negedges with stb high,
  // lat = edges after the accepting edge until rsp_valid is visible.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, output int stb_cycles, output int lat,
                         output bit timed_out);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    stb_cycles = 0; lat = 0; timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        timed_out = 1'b0;
        break;
      end
      if (stb_o) stb_cycles++;
      @(negedge clk);
      lat++;
    end
    if (timed_out) begin
      tests_run++; tests_failed++;
      $display("FAIL txn_wait: rsp_valid never rose within 40 cycles (addr %h)", addr);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({cyc_o, stb_o, we_o, rsp_valid, rsp_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: cyc/stb/we/rsp_valid/rsp_err = %b, want 00000",
               {cyc_o, stb_o, we_o, rsp_valid, rsp_err});
    end
    tests_run++;
    if ({adr_o, dat_o, sel_o, rsp_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: adr %h dat %h sel %h rdata %h, want all 0",
               adr_o, dat_o, sel_o, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: req_ready %b, want 1", req_ready);
    end
  endtask

  task automatic test_write_gpio();
    int sc, lat; bit to;
    mode = M_GPIO;
    run_txn(1'b1, 32'h2, 32'h1, 4'hF, sc, lat, to);
    tests_run++;
    if (sc !== 2) begin
      tests_failed++; $display("FAIL wr_stb_cycles: got %0d, want 2", sc);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++; $display("FAIL wr_latency: got %0d, want 2", lat);
    end
    tests_run++;
    if ({rsp_err, rsp_rdata, stb_o} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL wr_rsp: err %b rdata %h stb %b, want 0 00000000 0", rsp_err, rsp_rdata, stb_o);
    end
    tests_run++;
    if (gpio_out[2] !== 1'b1) begin
      tests_failed++; $display("FAIL wr_gpio_bit2: got %b, want 1", gpio_out[2]);
    end
    release_rsp();
  endtask

  task automatic test_read_gpio();
    int sc, lat; bit to;
    mode = M_GPIO;
    gpio_i = 4'b0100;
    run_txn(1'b0, 32'h2, 32'hDEAD_BEEF, 4'hF, sc, lat, to);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++; $display("FAIL rd_latency: got %0d, want 2", lat);
    end
    tests_run++;
    if ({rsp_err, rsp_rdata} !== {1'b0, 32'h1}) begin
      tests_failed++;
      $display("FAIL rd_rsp: err %b rdata %h, want 0 00000001", rsp_err, rsp_rdata);
    end
    release_rsp();
  endtask

  task automatic test_timeout();
    int sc, lat; bit to;
    mode = M_NONE;
    rand_dat = 32'hA5A5_5A5A;
    run_txn(1'b0, 32'h40, 32'h0, 4'h3, sc, lat, to);
    tests_run++;
    if (sc !== TMO) begin
      tests_failed++; $display("FAIL tmo_stb_cycles: got %0d, want %0d", sc, TMO);
    end
    tests_run++;
    if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL tmo_rsp: err %b rdata %h, want 1 00000000", rsp_err, rsp_rdata);
    end
    release_rsp();
  endtask

  task automatic test_err_ack_priority();
    int sc, lat; bit to;
    mode = M_DELAY;
    dly_w = 1; dly_ack = 1'b1; dly_err = 1'b1; rand_dat = 32'h1234_5678;
    run_txn(1'b0, 32'h8, 32'h0, 4'hF, sc, lat, to);
    tests_run++;
    if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL prio_err_ack: err %b rdata %h, want 1 00000000", rsp_err, rsp_rdata);
    end
    release_rsp();
    dly_w = TMO - 1; dly_ack = 1'b1; dly_err = 1'b0; rand_dat = 32'h0BAD_F00D;
    run_txn(1'b0, 32'hC, 32'h0, 4'hF, sc, lat, to);
    tests_run++;
    if ({rsp_err, rsp_rdata, lat} !== {1'b0, 32'h0BAD_F00D, TMO}) begin
      tests_failed++;
      $display("FAIL prio_ack_at_timeout: err %b rdata %h lat %0d, want 0 0badf00d %0d",
               rsp_err, rsp_rdata, lat, TMO);
    end
    release_rsp();
  endtask

  task automatic test_random();
    int sc, lat; bit to;
    int exp_k; logic exp_err; logic [31:0] exp_rd;
    logic we; logic [31:0] addr, wdata; logic [3:0] sel;
    mode = M_DELAY;
    for (int n = 0; n < 20; n++) begin
      dly_w = $urandom_range(0, 5);
      dly_ack = 1'($urandom); dly_err = 1'($urandom);
      rand_dat = $urandom;
      we = 1'($urandom); addr = $urandom; wdata = $urandom; sel = 4'($urandom);
      // Reference: first responder signal within TMO strobe cycles ends the cycle,
      // otherwise the watchdog ends it with an error after exactly TMO cycles.
      if ((dly_ack || dly_err) && (dly_w + 1 <= TMO)) begin
        exp_k = dly_w + 1; exp_err = dly_err;
        exp_rd = (dly_err || we) ? 32'h0 : rand_dat;
      end else begin
        exp_k = TMO; exp_err = 1'b1; exp_rd = 32'h0;
      end
      run_txn(we, addr, wdata, sel, sc, lat, to);
      tests_run++;
      if (sc !== exp_k || lat !== exp_k) begin
        tests_failed++;
        $display("FAIL rnd%0d_timing: stb %0d lat %0d, want %0d", n, sc, lat, exp_k);
      end
      tests_run++;
      if ({rsp_err, rsp_rdata} !== {exp_err, exp_rd}) begin
        tests_failed++;
        $display("FAIL rnd%0d_rsp: err %b rdata %h, want %b %h", n, rsp_err, rsp_rdata,
                 exp_err, exp_rd);
      end
      tests_run++;
      if ({adr_o, dat_o, sel_o, we_o} !== {addr, wdata, sel, we}) begin
        tests_failed++;
        $display("FAIL rnd%0d_bus_hold: adr %h dat %h sel %h we %b, want %h %h %h %b", n,
                 adr_o, dat_o, sel_o, we_o, addr, wdata, sel, we);
      end
      release_rsp();
    end
  endtask

  task automatic test_backpressure();
    int sc, lat; bit to;
    mode = M_GPIO;
    gpio_i = 4'b0010;
    run_txn(1'b0, 32'h1, 32'h0, 4'hF, sc, lat, to);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3; req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      tests_run++;
      if ({rsp_valid, rsp_rdata, req_ready, adr_o, stb_o} !== {1'b1, 32'h1, 1'b0, 32'h1, 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: valid %b rdata %h ready %b adr %h stb %b, want 1 00000001 0 00000001 0",
                 c, rsp_valid, rsp_rdata, req_ready, adr_o, stb_o);
      end
    end
    req_valid = 1'b0;
    release_rsp();
    tests_run++;
    if ({rsp_valid, req_ready, stb_o, adr_o} !== {1'b0, 1'b1, 1'b0, 32'h1}) begin
      tests_failed++;
      $display("FAIL bp_release: valid %b ready %b stb %b adr %h, want 0 1 0 00000001",
               rsp_valid, req_ready, stb_o, adr_o);
    end
  endtask

  task automatic test_reset_mid_bus();
    mode = M_NONE;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h77; req_sel = 4'h1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stb_o !== 1'b1) begin
      tests_failed++; $display("FAIL mid_bus_active: stb %b, want 1", stb_o);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({cyc_o, stb_o, rsp_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_bus_async_drop: cyc %b stb %b valid %b, want 000", cyc_o, stb_o, rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (TMO + 2) @(negedge clk);
    tests_run++;
    if ({rsp_valid, req_ready, stb_o, adr_o} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL mid_bus_after: valid %b ready %b stb %b adr %h, want 0 1 0 00000000",
               rsp_valid, req_ready, stb_o, adr_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_gpio();
    test_read_gpio();
    test_timeout();
    test_err_ack_priority();
    test_random();
    test_backpressure();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
